prio_irq_encoder: RTL and testbench

//  Parametrised, registered N-input priority encoder with sticky request latches, per-input mask,

---
 rtl/prio_irq_encoder.sv | 59 +++++
 tb/tb_prio_irq_encoder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/prio_irq_encoder.sv
// prio_irq_encoder: registered N-input priority encoder with sticky requests, mask, fixed/rotating priority and valid/ack handshake
module prio_irq_encoder #(
  parameter int N = 8,
  parameter int W = $clog2(N),
  parameter bit REQ_ACT_LO = 1'b1,
  parameter bit ROTATE = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ei,
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  input  logic         clr,
  input  logic         ack,
  output logic [W-1:0] code,
  output logic         valid,
  output logic         eo
);
  logic [N-1:0] pend, r, clr_vec, pend_n, c_n;
  logic [W-1:0] rr_ptr, rr_n, win, idx;
  logic         fire, hold, brk, valid_n;
  // next-state pending bits, candidates and the hold/break decision for the current grant
  always_comb begin
    fire = ack & valid;
    r = REQ_ACT_LO ? ~req : req;
    clr_vec = clr ? '1 : (fire ? (N'(1) << code) : '0);
    pend_n = (pend & ~clr_vec) | r;
    c_n = pend_n & ~mask;
    rr_n = fire ? code : rr_ptr;
    hold = valid & ~ack & c_n[code];
    brk = valid & ~ack & ~c_n[code];
    valid_n = ei & (|c_n) & ~brk;
  end
  // winner search: the last index visited has top priority (N-1 when fixed, rr_n-1 when rotating)
  always_comb begin
    win = '0;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      idx = ROTATE ? W'((int'(rr_n) + N - k) % N) : W'(N - k);
      win = c_n[idx] ? idx : win;
    end
  end
  // pending latches, rotation pointer and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend   <= '0;
      code   <= '0;
      valid  <= 1'b0;
      eo     <= 1'b0;
      rr_ptr <= W'(N - 1);
    end else begin
      pend   <= pend_n;
      rr_ptr <= rr_n;
      valid  <= valid_n;
      code   <= (valid_n & ~hold) ? win : code;
      eo     <= ei & ~(|c_n);
    end
  end
endmodule

// File: tb/tb_prio_irq_encoder.sv
// tb_prio_irq_encoder: randomized and directed scoreboard bench for fixed and rotating encoder instances
module tb_prio_irq_encoder;
  localparam int N = 8;
  logic clk = 1'b0, reset = 1'b1, ei = 1'b1, clr = 1'b0, ack = 1'b0;
  logic [N-1:0] req = '1, mask = '0;
  logic [2:0] code_f, code_r;
  logic valid_f, valid_r, eo_f, eo_r;
  int checks = 0, errors = 0;
  typedef struct {int inst; bit v; int code; bit eo;} exp_t;
  exp_t q[$];
  bit mp[2][N];
  int mcode[2], mrr[2];
  bit mvalid[2];

  always #5 clk = ~clk;

  prio_irq_encoder #(.N(N), .REQ_ACT_LO(1'b1), .ROTATE(1'b0)) dut_f (
    .clk(clk), .reset(reset), .ei(ei), .req(req), .mask(mask), .clr(clr), .ack(ack),
    .code(code_f), .valid(valid_f), .eo(eo_f));
  prio_irq_encoder #(.N(N), .REQ_ACT_LO(1'b1), .ROTATE(1'b1)) dut_r (
    .clk(clk), .reset(reset), .ei(ei), .req(req), .mask(mask), .clr(clr), .ack(ack),
    .code(code_r), .valid(valid_r), .eo(eo_r));

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < N; i++) mp[m][i] = 1'b0;
      mcode[m] = 0;
      mvalid[m] = 1'b0;
      mrr[m] = N - 1;
    end
  endtask

  // one clock of the reference: instance 0 fixed priority, instance 1 rotating
  task automatic model_step(int m);
    bit fire, any;
    bit np[N];
    bit cand[N];
    int rr, win, idx;
    exp_t e;
    fire = ack && mvalid[m];
    any = 1'b0;
    win = -1;
    for (int i = 0; i < N; i++) begin
      np[i] = (mp[m][i] && !(clr || (fire && i == mcode[m]))) || (req[i] == 1'b0);
      cand[i] = np[i] && !mask[i];
      if (cand[i]) begin
        any = 1'b1;
        if (m == 0) win = i;
      end
    end
    rr = fire ? mcode[m] : mrr[m];
    if (m == 1)
      for (int k = 1; k <= N; k++) begin
        idx = (rr - k + N) % N;
        if (cand[idx] && win < 0) win = idx;
      end
    if (mvalid[m] && !ack && !cand[mcode[m]]) mvalid[m] = 1'b0;
    else if (mvalid[m] && !ack) mvalid[m] = ei;
    else begin
      mvalid[m] = ei && any;
      if (mvalid[m]) mcode[m] = win;
    end
    mrr[m] = rr;
    for (int i = 0; i < N; i++) mp[m][i] = np[i];
    e.inst = m;
    e.v = mvalid[m];
    e.code = mcode[m];
    e.eo = ei && !any;
    q.push_back(e);
  endtask

  task automatic cyc();
    model_step(0);
    model_step(1);
    @(posedge clk);
    @(negedge clk);
  endtask

  // monitor: compares every presented output against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (q.size() != 0) begin
        e = q.pop_front();
        if (e.inst == 0) begin
          chk("valid_fixed", valid_f, e.v);
          chk("code_fixed", code_f, e.code);
          chk("eo_fixed", eo_f, e.eo);
        end else begin
          chk("valid_rot", valid_r, e.v);
          chk("code_rot", code_r, e.code);
          chk("eo_rot", eo_r, e.eo);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout no summary reached");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", valid_f, 0);
    chk("reset_eo", eo_r, 0);
    chk("reset_code", code_r, 0);
    @(negedge clk);
    reset = 1'b0;
    cyc();
    // single request on line 2, held until acked
    req = 8'hFB; cyc(); req = '1;
    cyc(); cyc();
    ack = 1'b1; cyc(); ack = 1'b0; cyc();
    // lines 1, 5 and 7 pulsed together, acked one at a time
    req = ~8'hA2; cyc(); req = '1;
    repeat (3) begin cyc(); ack = 1'b1; cyc(); ack = 1'b0; end
    cyc(); cyc();
    // lines 3 and 6 held, ack every cycle
    req = ~8'h48; ack = 1'b1; repeat (6) cyc();
    req = '1; repeat (3) cyc(); ack = 1'b0;
    // grant line 0 so rotation restarts from the top, then all lines held
    req = ~8'h01; cyc(); req = '1; cyc(); ack = 1'b1; cyc(); ack = 1'b0; cyc();
    req = '0; ack = 1'b1; repeat (10) cyc();
    req = '1; repeat (10) cyc(); ack = 1'b0; cyc();
    // no preemption of an unacked grant
    req = ~8'h04; cyc(); req = '1; cyc();
    req = ~8'h80; cyc(); req = '1; cyc(); cyc();
    ack = 1'b1; cyc(); ack = 1'b0; cyc(); ack = 1'b1; cyc(); ack = 1'b0; cyc();
    // same-cycle ack and re-request, then clr with ack
    req = ~8'h10; cyc(); req = '1; cyc();
    ack = 1'b1; req = ~8'h10; cyc(); req = '1; ack = 1'b0; cyc();
    clr = 1'b1; ack = 1'b1; cyc(); clr = 1'b0; ack = 1'b0; cyc();
    // masking the held index, then ei dropped mid-grant
    req = ~8'h05; cyc(); req = '1; cyc();
    mask = 8'h04; cyc(); cyc();
    ack = 1'b1; cyc(); ack = 1'b0; mask = '0; cyc();
    ack = 1'b1; cyc(); ack = 1'b0; cyc();
    req = ~8'h08; cyc(); req = '1; cyc();
    ei = 1'b0; cyc(); cyc(); ei = 1'b1; cyc();
    ack = 1'b1; cyc(); cyc(); ack = 1'b0;
    // asynchronous reset mid-grant
    req = ~8'h20; cyc(); req = '1; cyc();
    reset = 1'b1;
    #1;
    chk("async_valid_fixed", valid_f, 0);
    chk("async_valid_rot", valid_r, 0);
    chk("async_code_fixed", code_f, 0);
    chk("async_code_rot", code_r, 0);
    chk("async_eo_fixed", eo_f, 0);
    chk("async_eo_rot", eo_r, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    cyc();
    // randomized traffic
    repeat (400) begin
      req = ~(N'($urandom) & N'($urandom));
      mask = N'($urandom) & N'($urandom) & N'($urandom);
      clr = ($urandom_range(0, 19) == 0);
      ack = $urandom_range(0, 1) != 0;
      ei = ($urandom_range(0, 9) != 0);
      cyc();
    end
    req = '1; mask = '0; clr = 1'b0; ack = 1'b0; ei = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
